// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared constants for the multiplexed 7-segment scanner.
//  - SEG_* : active-high segment patterns {g,f,e,d,c,b,a} for hex digits 0..F
//  - SEG_OFF : all segments dark (active-high view)
//  - hex2seg() : 4-bit hex value -> active-high segment pattern
// -----------------------------------------------------------------------------
package seg7_pkg;

   localparam logic [6:0] SEG_0   = 7'h3F;
   localparam logic [6:0] SEG_1   = 7'h06;
   localparam logic [6:0] SEG_2   = 7'h5B;
   localparam logic [6:0] SEG_3   = 7'h4F;
   localparam logic [6:0] SEG_4   = 7'h66;
   localparam logic [6:0] SEG_5   = 7'h6D;
   localparam logic [6:0] SEG_6   = 7'h7D;  // with top tail (a lit)
   localparam logic [6:0] SEG_7   = 7'h07;
   localparam logic [6:0] SEG_8   = 7'h7F;
   localparam logic [6:0] SEG_9   = 7'h6F;  // with bottom tail (d lit)
   localparam logic [6:0] SEG_A   = 7'h77;
   localparam logic [6:0] SEG_B   = 7'h7C;  // lowercase b
   localparam logic [6:0] SEG_C   = 7'h39;
   localparam logic [6:0] SEG_D   = 7'h5E;  // lowercase d
   localparam logic [6:0] SEG_E   = 7'h79;
   localparam logic [6:0] SEG_F   = 7'h71;
   localparam logic [6:0] SEG_OFF = 7'h00;

   function automatic logic [6:0] hex2seg(input logic [3:0] hex);
      logic [6:0] seg;
      case (hex)
         4'h0:    seg = SEG_0;
         4'h1:    seg = SEG_1;
         4'h2:    seg = SEG_2;
         4'h3:    seg = SEG_3;
         4'h4:    seg = SEG_4;
         4'h5:    seg = SEG_5;
         4'h6:    seg = SEG_6;
         4'h7:    seg = SEG_7;
         4'h8:    seg = SEG_8;
         4'h9:    seg = SEG_9;
         4'hA:    seg = SEG_A;
         4'hB:    seg = SEG_B;
         4'hC:    seg = SEG_C;
         4'hD:    seg = SEG_D;
         4'hE:    seg = SEG_E;
         4'hF:    seg = SEG_F;
         default: seg = SEG_OFF;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// -----------------------------------------------------------------------------
// seg7_hex_decode
// Combinational hex digit to active-high segment pattern decoder.
// Ports:
//  hex_i  in  4  hex value
//  seg_o  out 7  segments {g,f,e,d,c,b,a}, 1 = lit
// -----------------------------------------------------------------------------
module seg7_hex_decode
   import seg7_pkg::*;
(
   input  logic [3:0] hex_i,
   output logic [6:0] seg_o
);

   // Table lookup of the segment pattern
   always_comb begin
      seg_o = hex2seg(hex_i);
   end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg7_scan_ctrl
// Time-multiplexes N_DIGITS hex digits onto shared segment lines with
// frame-synchronous double-buffered load, per-digit DP/blank masks,
// leading-zero suppression, PWM brightness and a frame-done strobe.
// Ports:
//  clk, rst          clock, synchronous active-high reset
//  data_i/dp_i/blank_i  digit values, DP requests, blank mask (captured on load)
//  load              capture inputs into the shadow registers
//  lz_en             leading-zero suppression enable (used live)
//  bright            PWM level, 0 = dimmest, all-ones = full slot
//  frame_done        1-cycle pulse after the last digit slot ends
//  led_en            digit enables (one-hot active, polarity EN_ACT_LOW)
//  led_seg, led_dp   segments {g,f,e,d,c,b,a} and DP (polarity SEG_ACT_LOW)
// -----------------------------------------------------------------------------
module seg7_scan_ctrl
   import seg7_pkg::*;
#(
   parameter int unsigned N_DIGITS    = 8,
   parameter int unsigned SCAN_CYCLES = 200000,
   parameter int unsigned BR_W        = 3,
   parameter bit          EN_ACT_LOW  = 1'b1,
   parameter bit          SEG_ACT_LOW = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [4*N_DIGITS-1:0] data_i,
   input  logic [N_DIGITS-1:0]   dp_i,
   input  logic [N_DIGITS-1:0]   blank_i,
   input  logic                  load,
   input  logic                  lz_en,
   input  logic [BR_W-1:0]       bright,
   output logic                  frame_done,
   output logic [N_DIGITS-1:0]   led_en,
   output logic [6:0]            led_seg,
   output logic                  led_dp
);

   localparam int unsigned CNT_W = $clog2(SCAN_CYCLES);
   localparam int unsigned DIG_W = $clog2(N_DIGITS);
   localparam int unsigned SLICE = SCAN_CYCLES >> BR_W;

   localparam logic [CNT_W-1:0]    SLOT_LAST = CNT_W'(SCAN_CYCLES - 1);
   localparam logic [DIG_W-1:0]    DIG_LAST  = DIG_W'(N_DIGITS - 1);
   localparam logic [N_DIGITS-1:0] EN_DARK   = EN_ACT_LOW ? {N_DIGITS{1'b1}} : {N_DIGITS{1'b0}};
   localparam logic [6:0]          SEG_DARK  = SEG_ACT_LOW ? 7'h7F : 7'h00;
   localparam logic                DP_DARK   = SEG_ACT_LOW ? 1'b1 : 1'b0;

   logic [CNT_W-1:0]      slot_cnt_q, slot_cnt_d;
   logic [DIG_W-1:0]      dig_idx_q, dig_idx_d;
   logic [4*N_DIGITS-1:0] shadow_data_q, shadow_data_d, active_data_q, active_data_d;
   logic [N_DIGITS-1:0]   shadow_dp_q, shadow_dp_d, active_dp_q, active_dp_d;
   logic [N_DIGITS-1:0]   shadow_blank_q, shadow_blank_d, active_blank_q, active_blank_d;
   logic                  pending_q, pending_d;
   logic                  frame_done_q, frame_done_d;
   logic [N_DIGITS-1:0]   led_en_q, led_en_d;
   logic [6:0]            led_seg_q, led_seg_d;
   logic                  led_dp_q, led_dp_d;

   logic                  slot_wrap_s, boundary_s;
   logic [3:0]            cur_hex_s;
   logic [6:0]            cur_seg_s;
   logic [N_DIGITS-1:0]   lz_supp_s;
   logic                  zero_run_s;
   logic [31:0]           pwm_thresh_s;
   logic                  pwm_on_s, dig_on_s;
   logic [N_DIGITS-1:0]   en_onehot_s;

   seg7_hex_decode u_dec (
      .hex_i (cur_hex_s),
      .seg_o (cur_seg_s)
   );

   // Slot counter, digit index and frame boundary
   always_comb begin
      slot_wrap_s  = (slot_cnt_q == SLOT_LAST);
      boundary_s   = slot_wrap_s && (dig_idx_q == DIG_LAST);
      frame_done_d = boundary_s;
      slot_cnt_d   = slot_wrap_s ? {CNT_W{1'b0}} : (slot_cnt_q + CNT_W'(1));
      if (slot_wrap_s) begin
         dig_idx_d = (dig_idx_q == DIG_LAST) ? {DIG_W{1'b0}} : (dig_idx_q + DIG_W'(1));
      end else begin
         dig_idx_d = dig_idx_q;
      end
   end

   // Double-buffered load: active set only changes at the frame boundary
   always_comb begin
      shadow_data_d  = shadow_data_q;
      shadow_dp_d    = shadow_dp_q;
      shadow_blank_d = shadow_blank_q;
      active_data_d  = active_data_q;
      active_dp_d    = active_dp_q;
      active_blank_d = active_blank_q;
      pending_d      = pending_q;
      if (boundary_s) begin
         pending_d = 1'b0;
         if (load) begin
            // load on the boundary itself bypasses the shadow stage
            shadow_data_d  = data_i;
            shadow_dp_d    = dp_i;
            shadow_blank_d = blank_i;
            active_data_d  = data_i;
            active_dp_d    = dp_i;
            active_blank_d = blank_i;
         end else if (pending_q) begin
            active_data_d  = shadow_data_q;
            active_dp_d    = shadow_dp_q;
            active_blank_d = shadow_blank_q;
         end else begin
            active_data_d  = active_data_q;
         end
      end else if (load) begin
         shadow_data_d  = data_i;
         shadow_dp_d    = dp_i;
         shadow_blank_d = blank_i;
         pending_d      = 1'b1;
      end else begin
         pending_d      = pending_q;
      end
   end

   // Leading-zero mask: walk down from the top digit while digits stay zero
   always_comb begin
      zero_run_s = 1'b1;
      lz_supp_s  = {N_DIGITS{1'b0}};
      for (int k = N_DIGITS - 1; k >= 0; k--) begin
         zero_run_s   = zero_run_s & (active_data_q[4*k +: 4] == 4'h0);
         lz_supp_s[k] = lz_en & zero_run_s & (k != 0);
      end
   end

   // Current digit select, PWM window and next output values
   always_comb begin
      cur_hex_s    = active_data_q[{dig_idx_q, 2'b00} +: 4];
      pwm_thresh_s = (32'(bright) + 32'd1) * 32'(SLICE);
      pwm_on_s     = (32'(slot_cnt_q) < pwm_thresh_s);
      dig_on_s     = pwm_on_s & ~active_blank_q[dig_idx_q] & ~lz_supp_s[dig_idx_q];
      en_onehot_s  = dig_on_s ? ({{(N_DIGITS-1){1'b0}}, 1'b1} << dig_idx_q) : {N_DIGITS{1'b0}};
      led_en_d     = EN_ACT_LOW ? ~en_onehot_s : en_onehot_s;
      led_seg_d    = SEG_ACT_LOW ? ~cur_seg_s : cur_seg_s;
      led_dp_d     = SEG_ACT_LOW ? ~active_dp_q[dig_idx_q] : active_dp_q[dig_idx_q];
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         slot_cnt_q     <= {CNT_W{1'b0}};
         dig_idx_q      <= {DIG_W{1'b0}};
         shadow_data_q  <= {(4*N_DIGITS){1'b0}};
         shadow_dp_q    <= {N_DIGITS{1'b0}};
         shadow_blank_q <= {N_DIGITS{1'b0}};
         active_data_q  <= {(4*N_DIGITS){1'b0}};
         active_dp_q    <= {N_DIGITS{1'b0}};
         active_blank_q <= {N_DIGITS{1'b0}};
         pending_q      <= 1'b0;
         frame_done_q   <= 1'b0;
         led_en_q       <= EN_DARK;
         led_seg_q      <= SEG_DARK;
         led_dp_q       <= DP_DARK;
      end else begin
         slot_cnt_q     <= slot_cnt_d;
         dig_idx_q      <= dig_idx_d;
         shadow_data_q  <= shadow_data_d;
         shadow_dp_q    <= shadow_dp_d;
         shadow_blank_q <= shadow_blank_d;
         active_data_q  <= active_data_d;
         active_dp_q    <= active_dp_d;
         active_blank_q <= active_blank_d;
         pending_q      <= pending_d;
         frame_done_q   <= frame_done_d;
         led_en_q       <= led_en_d;
         led_seg_q      <= led_seg_d;
         led_dp_q       <= led_dp_d;
      end
   end

   assign frame_done = frame_done_q;
   assign led_en     = led_en_q;
   assign led_seg    = led_seg_q;
   assign led_dp     = led_dp_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_ctrl
// Directed bench for seg7_scan_ctrl (8 digits, 16-cycle slots, 2-bit
// brightness, active-low enables and segments). Expected segment codes are
// hand-computed active-low values.
// -----------------------------------------------------------------------------
module tb_seg7_scan_ctrl;

   localparam int N  = 8;
   localparam int SC = 16;
   localparam int BW = 2;

   // active-low segment codes
   localparam logic [6:0] L0 = 7'h40, L1 = 7'h79, L2 = 7'h24, L3 = 7'h30, L4 = 7'h19;
   localparam logic [6:0] L5 = 7'h12, LA = 7'h08, LB = 7'h03, LC = 7'h46, LD = 7'h21;

   localparam logic [55:0] SEGS_SCAN = {L1, L2, L3, L4, LA, LB, LC, LD};
   localparam logic [55:0] SEGS_ZERO = {L0, L0, L0, L0, L0, L0, L0, L0};
   localparam logic [55:0] SEGS_50   = {L0, L0, L0, L0, L0, L0, L5, L0};

   logic          clk = 1'b0;
   logic          rst;
   logic [4*N-1:0] data_i;
   logic [N-1:0]  dp_i, blank_i;
   logic          load, lz_en;
   logic [BW-1:0] bright;
   logic          frame_done;
   logic [N-1:0]  led_en;
   logic [6:0]    led_seg;
   logic          led_dp;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   seg7_scan_ctrl #(
      .N_DIGITS(N), .SCAN_CYCLES(SC), .BR_W(BW), .EN_ACT_LOW(1'b1), .SEG_ACT_LOW(1'b1)
   ) dut (
      .clk(clk), .rst(rst), .data_i(data_i), .dp_i(dp_i), .blank_i(blank_i),
      .load(load), .lz_en(lz_en), .bright(bright), .frame_done(frame_done),
      .led_en(led_en), .led_seg(led_seg), .led_dp(led_dp)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_fd();
      int n;
      n = 0;
      while (frame_done !== 1'b1 && n < 300) begin
         tick();
         n++;
      end
      check_val("fd_wait", {31'd0, frame_done}, 32'd1);
   endtask

   // Called right after frame_done is seen; checks one full frame cycle by cycle.
   task automatic run_frame(input string tag, input logic [7:0] en_mask, input logic [55:0] segs,
                            input logic [7:0] dp_mask, input int on_cyc);
      logic [7:0] exp_en;
      logic [7:0] one;
      one = 8'd1;
      for (int d = 0; d < N; d++) begin
         for (int s = 0; s < SC; s++) begin
            tick();
            exp_en = (en_mask[d] && (s < on_cyc)) ? ~(one << d) : 8'hFF;
            check_val({tag, "_en"}, {24'd0, led_en}, {24'd0, exp_en});
            check_val({tag, "_seg"}, {25'd0, led_seg}, {25'd0, segs[7*d +: 7]});
            check_val({tag, "_dp"}, {31'd0, led_dp}, {31'd0, ~dp_mask[d]});
            check_val({tag, "_fd"}, {31'd0, frame_done}, {31'd0, (d == N-1) && (s == SC-1)});
         end
      end
   endtask

   task automatic check_reset_outs(input string tag);
      check_val({tag, "_en"}, {24'd0, led_en}, 32'h0000_00FF);
      check_val({tag, "_seg"}, {25'd0, led_seg}, 32'h0000_007F);
      check_val({tag, "_dp"}, {31'd0, led_dp}, 32'd1);
      check_val({tag, "_fd"}, {31'd0, frame_done}, 32'd0);
   endtask

   task automatic do_load(input logic [31:0] d, input logic [7:0] dp, input logic [7:0] bl);
      data_i  = d;
      dp_i    = dp;
      blank_i = bl;
      load    = 1'b1;
      tick();
      load    = 1'b0;
   endtask

   initial begin
      rst = 1'b1; data_i = 32'd0; dp_i = 8'd0; blank_i = 8'd0;
      load = 1'b0; lz_en = 1'b0; bright = 2'd3;

      // reset state
      repeat (3) tick();
      check_reset_outs("rst");
      rst = 1'b0;
      tick();
      check_val("rel_en", {24'd0, led_en}, 32'h0000_00FE);
      check_val("rel_seg", {25'd0, led_seg}, {25'd0, L0});

      // basic scan
      wait_fd();
      do_load(32'h1234_ABCD, 8'h00, 8'h00);
      wait_fd();
      run_frame("scan", 8'hFF, SEGS_SCAN, 8'h00, 16);

      // mid-frame load waits for the boundary
      repeat (40) tick();
      do_load(32'h0000_0000, 8'h00, 8'h00);
      repeat (40) tick();
      check_val("tear_en", {24'd0, led_en}, 32'h0000_00DF);
      check_val("tear_seg", {25'd0, led_seg}, {25'd0, L3});
      wait_fd();
      run_frame("tearnew", 8'hFF, SEGS_ZERO, 8'h00, 16);

      // load in the boundary cycle applies immediately
      repeat (127) tick();
      do_load(32'h0000_0050, 8'h00, 8'h00);
      check_val("bnd_fd", {31'd0, frame_done}, 32'd1);
      run_frame("bnd", 8'hFF, SEGS_50, 8'h00, 16);

      // leading-zero suppression
      lz_en = 1'b1;
      run_frame("lz50", 8'h03, SEGS_50, 8'h00, 16);
      do_load(32'h0000_0000, 8'h00, 8'h00);
      wait_fd();
      run_frame("lz0", 8'h01, SEGS_ZERO, 8'h00, 16);
      lz_en = 1'b0;

      // PWM brightness
      bright = 2'd1;
      run_frame("pwm1", 8'hFF, SEGS_ZERO, 8'h00, 8);
      bright = 2'd0;
      run_frame("pwm0", 8'hFF, SEGS_ZERO, 8'h00, 4);
      bright = 2'd3;

      // DP and blank masks
      do_load(32'h1234_ABCD, 8'h04, 8'h80);
      wait_fd();
      run_frame("mask", 8'h7F, SEGS_SCAN, 8'h04, 16);

      // reset mid-frame discards pending shadow data
      repeat (20) tick();
      do_load(32'h1234_ABCD, 8'hFF, 8'h00);
      rst = 1'b1;
      repeat (2) tick();
      check_reset_outs("rst2");
      rst = 1'b0;
      tick();
      check_val("rel2_en", {24'd0, led_en}, 32'h0000_00FE);
      wait_fd();
      run_frame("postrst", 8'hFF, SEGS_ZERO, 8'h00, 16);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
